// File: rtl/exec_pipe_ctrl.sv
// Execution-stage hazard controller: forwarding selects, load-use bubbles, multicycle hold, jump flush.
// Optional performance counters are enabled by defining EXEC_CTRL_PERF_EN.
module exec_pipe_ctrl #(
  parameter int RA_W   = 5,
  parameter int MC_LAT = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic [RA_W-1:0] id_rd,
  input  logic            id_reg_wr,
  input  logic            id_mem_rd,
  input  logic            id_mc,
  input  logic            ex_jump_flag,
  output logic            stall_pc,
  output logic            stall_ifid,
  output logic            flush_ifid,
  output logic            ex_busy,
  output logic [1:0]      fwd_a_sel,
  output logic [1:0]      fwd_b_sel
`ifdef EXEC_CTRL_PERF_EN
  ,
  output logic [31:0]     perf_stall_cyc,
  output logic [31:0]     perf_flush_cnt
`endif
);

  localparam int CNT_W = $clog2(MC_LAT);
  localparam logic [CNT_W-1:0] MC_LOAD = CNT_W'(MC_LAT - 1);

  typedef enum logic [1:0] {MODE_NORM, MODE_LU, MODE_JUMP, MODE_BUSY} mode_t;

  logic             vld_p0, vld_p1, vld_p2;
  logic [RA_W-1:0]  ex_rs1_p0, ex_rs2_p0, ex_rd_p0;
  logic             ex_wr_p0, ex_mrd_p0, ex_mc_p0;
  logic [RA_W-1:0]  mem_rd_p1, wb_rd_p2;
  logic             mem_wr_p1, wb_wr_p2;
  logic [CNT_W-1:0] mc_cnt;
  logic             jump, lu;
  mode_t            mode;

  function automatic logic fwd_hit(input logic v, input logic wr,
                                   input logic [RA_W-1:0] rd, input logic [RA_W-1:0] rs);
    return v & wr & (rd != '0) & (rd == rs);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] rs);
    if (!vld_p0)                                  return 2'b00;
    else if (fwd_hit(vld_p1, mem_wr_p1, mem_rd_p1, rs)) return 2'b01;
    else if (fwd_hit(vld_p2, wb_wr_p2, wb_rd_p2, rs))   return 2'b10;
    else                                          return 2'b00;
  endfunction

  assign ex_busy = vld_p0 & ex_mc_p0 & (mc_cnt != '0);
  assign jump    = ex_jump_flag & vld_p0 & ~ex_busy;
  assign lu      = vld_p0 & ex_mrd_p0 & ex_wr_p0 & (ex_rd_p0 != '0) & id_valid &
                   ((id_use_rs1 & (id_rs1 == ex_rd_p0)) | (id_use_rs2 & (id_rs2 == ex_rd_p0)));

  always_comb begin
    mode = MODE_NORM;
    if (ex_busy)   mode = MODE_BUSY;
    else if (jump) mode = MODE_JUMP;
    else if (lu)   mode = MODE_LU;
  end

  assign stall_pc   = (mode == MODE_BUSY) | (mode == MODE_LU);
  assign stall_ifid = stall_pc;
  assign flush_ifid = (mode == MODE_JUMP);
  assign fwd_a_sel  = fwd_sel(ex_rs1_p0);
  assign fwd_b_sel  = fwd_sel(ex_rs2_p0);

  // ID -> EX (p0) -> MEM (p1) -> WB (p2): valid bits and multicycle counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      mc_cnt <= '0;
    end else begin
      vld_p2 <= vld_p1;
      case (mode)
        MODE_BUSY: begin
          vld_p1 <= 1'b0;
          mc_cnt <= mc_cnt - CNT_W'(1);
        end
        MODE_JUMP, MODE_LU: begin
          vld_p1 <= vld_p0;
          vld_p0 <= 1'b0;
        end
        default: begin
          vld_p1 <= vld_p0;
          vld_p0 <= id_valid;
          mc_cnt <= (id_valid & id_mc) ? MC_LOAD : '0;
        end
      endcase
    end
  end

  // Destination/source fields only matter when their valid bit is set
  always_ff @(posedge clock) begin
    wb_rd_p2  <= mem_rd_p1;
    wb_wr_p2  <= mem_wr_p1;
    mem_rd_p1 <= ex_rd_p0;
    mem_wr_p1 <= ex_wr_p0;
    if (mode == MODE_NORM) begin
      ex_rs1_p0 <= id_rs1;
      ex_rs2_p0 <= id_rs2;
      ex_rd_p0  <= id_rd;
      ex_wr_p0  <= id_reg_wr;
      ex_mrd_p0 <= id_mem_rd;
      ex_mc_p0  <= id_mc;
    end
  end

`ifdef EXEC_CTRL_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] c, input logic en);
    return (en && (c != 32'hFFFF_FFFF)) ? c + 32'd1 : c;
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_stall_cyc <= '0;
      perf_flush_cnt <= '0;
    end else begin
      perf_stall_cyc <= sat_inc(perf_stall_cyc, stall_pc);
      perf_flush_cnt <= sat_inc(perf_flush_cnt, flush_ifid);
    end
  end
`endif

endmodule

// File: tb/tb_exec_pipe_ctrl.sv
// Scoreboard bench for exec_pipe_ctrl: each driven ID cycle queues its expected control word,
// which is popped and compared on the following falling edge.
module tb_exec_pipe_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic       id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
  logic       id_reg_wr = 1'b0, id_mem_rd = 1'b0, id_mc = 1'b0;
  logic       ex_jump_flag = 1'b0;
  logic       stall_pc, stall_ifid, flush_ifid, ex_busy;
  logic [1:0] fwd_a_sel, fwd_b_sel;
`ifdef EXEC_CTRL_PERF_EN
  logic [31:0] perf_stall_cyc, perf_flush_cnt;
`endif

  logic [7:0] outs;
  logic [7:0] exp_q[$];
  string      tag_q[$];
  int         n_chk = 0;
  int         n_fail = 0;
  int         exp_stall = 0;
  int         exp_flush = 0;

  exec_pipe_ctrl #(.RA_W(5), .MC_LAT(4)) dut (
    .clock(clock), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_reg_wr(id_reg_wr), .id_mem_rd(id_mem_rd), .id_mc(id_mc),
    .ex_jump_flag(ex_jump_flag), .stall_pc(stall_pc), .stall_ifid(stall_ifid),
    .flush_ifid(flush_ifid), .ex_busy(ex_busy), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel)
`ifdef EXEC_CTRL_PERF_EN
    , .perf_stall_cyc(perf_stall_cyc), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  always #5 clock = ~clock;

  // {stall_pc, stall_ifid, flush_ifid, ex_busy, fwd_a_sel, fwd_b_sel}
  assign outs = {stall_pc, stall_ifid, flush_ifid, ex_busy, fwd_a_sel, fwd_b_sel};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input string tag, input logic v, input logic [4:0] rs1, input logic u1,
                      input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                      input logic wr, input logic mrd, input logic mc, input logic jmp,
                      input logic [7:0] exp);
    @(posedge clock);
    #1;
    id_valid = v; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
    id_rd = rd; id_reg_wr = wr; id_mem_rd = mrd; id_mc = mc; ex_jump_flag = jmp;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
  endtask

  task automatic nop(input string tag, input logic [7:0] exp);
    step(tag, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, exp);
  endtask

  task automatic alu(input string tag, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic [7:0] exp);
    step(tag, 1'b1, rs1, 1'b1, rs2, 1'b1, rd, 1'b1, 1'b0, 1'b0, 1'b0, exp);
  endtask

  task automatic ld(input string tag, input logic [4:0] rd, input logic [4:0] rs1,
                    input logic [7:0] exp);
    step(tag, 1'b1, rs1, 1'b1, 5'd0, 1'b0, rd, 1'b1, 1'b1, 1'b0, 1'b0, exp);
  endtask

  task automatic mul(input string tag, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic [7:0] exp);
    step(tag, 1'b1, rs1, 1'b1, rs2, 1'b1, rd, 1'b1, 1'b0, 1'b1, 1'b0, exp);
  endtask

  task automatic drain3();
    for (int i = 0; i < 3; i++) nop("drain", 8'h00);
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      exp_stall = 0;
      exp_flush = 0;
    end else if (exp_q.size() != 0) begin
      logic [7:0] e;
      string      t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      if (e[7]) exp_stall++;
      if (e[5]) exp_flush++;
      check(t, {24'd0, outs}, {24'd0, e});
    end
  end

  initial begin
    // Reset with hazardous ID inputs present
    id_valid = 1'b1; id_rs1 = 5'd7; id_use_rs1 = 1'b1; id_mc = 1'b1; ex_jump_flag = 1'b1;
    #3;
    check("rst_outs", {24'd0, outs}, 32'd0);
`ifdef EXEC_CTRL_PERF_EN
    check("rst_perf_stall", perf_stall_cyc, 32'd0);
    check("rst_perf_flush", perf_flush_cnt, 32'd0);
`endif
    id_valid = 1'b0; id_use_rs1 = 1'b0; id_mc = 1'b0; ex_jump_flag = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;

    // Reset asserted while a multicycle op holds EX
    mul("rm_mul", 5'd12, 5'd20, 5'd21, 8'h00);
    nop("rm_busy", 8'b1101_0000);
    @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("rm_async", {24'd0, outs}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    nop("rm_rel0", 8'h00);
    alu("rm_rel1", 5'd13, 5'd14, 5'd15, 8'h00);
    nop("rm_rel2", 8'h00);
    drain3();

    // add x5; add x6,x5,x1 -> MEM forward on rs1
    alu("f1_a", 5'd5, 5'd1, 5'd2, 8'h00);
    alu("f1_b", 5'd6, 5'd5, 5'd1, 8'h00);
    nop("f1_mem", 8'b0000_01_00);
    drain3();

    // add x5; nop; add x6,x5,x1 -> WB forward on rs1
    alu("f2_a", 5'd5, 5'd1, 5'd2, 8'h00);
    nop("f2_n", 8'h00);
    alu("f2_b", 5'd6, 5'd5, 5'd1, 8'h00);
    nop("f2_wb", 8'b0000_10_00);
    drain3();

    // Two writers of x5 in MEM and WB -> MEM wins on both operands
    alu("f3_a", 5'd5, 5'd1, 5'd2, 8'h00);
    alu("f3_b", 5'd5, 5'd3, 5'd4, 8'h00);
    alu("f3_c", 5'd6, 5'd5, 5'd5, 8'h00);
    nop("f3_pri", 8'b0000_01_01);
    drain3();

    // lw x7; add x8,x7,x7 -> one bubble, then WB forward on both
    ld("lu_ld", 5'd7, 5'd2, 8'h00);
    alu("lu_stall", 5'd8, 5'd7, 5'd7, 8'b1100_0000);
    alu("lu_retry", 5'd8, 5'd7, 5'd7, 8'h00);
    nop("lu_fwd", 8'b0000_10_10);
    drain3();

    // add x3; mul x9,x3,x4; add x10,x9,x1 -> 3 busy cycles, MEM bubbles, jump ignored while busy
    alu("mc_a", 5'd3, 5'd1, 5'd2, 8'h00);
    mul("mc_mul", 5'd9, 5'd3, 5'd4, 8'h00);
    alu("mc_busy1", 5'd10, 5'd9, 5'd1, 8'b1101_01_00);
    alu("mc_busy2", 5'd10, 5'd9, 5'd1, 8'b1101_10_00);
    step("mc_busy3", 1'b1, 5'd9, 1'b1, 5'd1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 1'b1, 8'b1101_00_00);
    alu("mc_last", 5'd10, 5'd9, 5'd1, 8'h00);
    nop("mc_fwd", 8'b0000_01_00);
    drain3();

    // Jump while ID is load-use dependent -> flush wins, EX bubbled; flag with empty EX ignored
    ld("jp_ld", 5'd7, 5'd2, 8'h00);
    step("jp_flush", 1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1, 8'b0010_0000);
    step("jp_after", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    drain3();

    // x0 is never a hazard or forward source
    alu("z_a", 5'd0, 5'd1, 5'd2, 8'h00);
    alu("z_b", 5'd1, 5'd0, 5'd0, 8'h00);
    nop("z_mem", 8'h00);
    nop("z_wb", 8'h00);
    ld("z_ld", 5'd0, 5'd2, 8'h00);
    alu("z_use", 5'd11, 5'd0, 5'd0, 8'h00);
    nop("z_end", 8'h00);
    drain3();

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clock);
    check("drain_q", exp_q.size(), 32'd0);
`ifdef EXEC_CTRL_PERF_EN
    check("perf_stall", perf_stall_cyc, exp_stall);
    check("perf_flush", perf_flush_cnt, exp_flush);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
